// File: rtl/lc3b_mem_arbiter_pkg.sv
// lc3b_types: shared LC-3b word/mask types plus the memory arbiter state encoding.
// Rev 1.0 - initial release.
`default_nettype none

package lc3b_types;

  typedef logic [15:0] lc3b_word;
  typedef logic [1:0]  lc3b_mem_wmask;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    I_ACC = 3'd1,
    D_ACC = 3'd2,
    D_PTR = 3'd3,
    D_FIN = 3'd4
  } lc3b_arb_state;

  localparam int LC3B_ARB_STREAK_W = 4;

endpackage

`default_nettype wire

// File: rtl/lc3b_mem_arbiter_perf.sv
// lc3b_arb_perf: wrapping conflict / fetch-stall counters; present only with LC3B_MEM_ARB_PERF_EN.
// Rev 1.0 - initial release.
`default_nettype none

`ifdef LC3B_MEM_ARB_PERF_EN
module lc3b_arb_perf (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        clear,
  input  logic        conflict,
  input  logic        stall,
  output logic [31:0] conflict_cnt,
  output logic [31:0] stall_cnt
);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      conflict_cnt <= '0;
      stall_cnt    <= '0;
    end else if (clear) begin
      conflict_cnt <= '0;
      stall_cnt    <= '0;
    end else begin
      if (conflict) conflict_cnt <= conflict_cnt + 32'd1;
      if (stall)    stall_cnt    <= stall_cnt + 32'd1;
    end
  end

endmodule
`endif

`default_nettype wire

// File: rtl/lc3b_mem_arbiter.sv
// lc3b_mem_arbiter: shares one memory port between fetch and MEM stage, sequencing LDI/STI pairs.
// Optional perf counters with LC3B_MEM_ARB_PERF_EN. Rev 1.0 - initial release.
`default_nettype none

module lc3b_mem_arbiter
  import lc3b_types::*;
#(
  parameter int unsigned MAX_D_STREAK = 4
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          i_read,
  input  lc3b_word      i_addr,
  output logic          i_resp,
  output lc3b_word      i_rdata,
  input  logic          d_read,
  input  logic          d_write,
  input  logic          d_indirect,
  input  lc3b_word      d_addr,
  input  lc3b_word      d_wdata,
  input  lc3b_mem_wmask d_wmask,
  output logic          d_resp,
  output lc3b_word      d_rdata,
  output logic          pmem_read,
  output logic          pmem_write,
  output lc3b_word      pmem_addr,
  output lc3b_word      pmem_wdata,
  output lc3b_mem_wmask pmem_wmask,
  input  logic          pmem_resp,
  input  lc3b_word      pmem_rdata
`ifdef LC3B_MEM_ARB_PERF_EN
  ,
  input  logic          perf_clear,
  output logic [31:0]   perf_conflict_cnt,
  output logic [31:0]   perf_fetch_stall_cnt
`endif
);

  localparam logic [LC3B_ARB_STREAK_W-1:0] STREAK_MAX = LC3B_ARB_STREAK_W'(MAX_D_STREAK);

  lc3b_arb_state                state;
  logic [LC3B_ARB_STREAK_W-1:0] streak;
  lc3b_word                     ptr;
  logic                         sv_write;
  lc3b_mem_wmask                sv_wmask;

  logic data_req;
  logic grant_d;
  logic grant_i;

  // Data wins unless it has already taken MAX_D_STREAK grants in a row while fetch waited.
  assign data_req = d_read | d_write;
  assign grant_d  = data_req && ((streak < STREAK_MAX) || !i_read);
  assign grant_i  = !grant_d && i_read;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      streak     <= '0;
      ptr        <= '0;
      sv_write   <= 1'b0;
      sv_wmask   <= '0;
      pmem_read  <= 1'b0;
      pmem_write <= 1'b0;
      pmem_addr  <= '0;
      pmem_wdata <= '0;
      pmem_wmask <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_d) begin
            pmem_addr  <= d_addr;
            pmem_wdata <= d_wdata;
            sv_write   <= d_write;
            sv_wmask   <= d_wmask;
            if (i_read)
              streak <= (streak == STREAK_MAX) ? streak : streak + 1'b1;
            else
              streak <= '0;
            if (d_indirect) begin
              // Pointer fetch is always a full-word read, whatever the final access is.
              state      <= D_PTR;
              pmem_read  <= 1'b1;
              pmem_write <= 1'b0;
              pmem_wmask <= 2'b11;
            end else begin
              state      <= D_ACC;
              pmem_read  <= !d_write;
              pmem_write <= d_write;
              pmem_wmask <= d_write ? d_wmask : 2'b11;
            end
          end else if (grant_i) begin
            state      <= I_ACC;
            streak     <= '0;
            pmem_addr  <= i_addr;
            pmem_wdata <= '0;
            pmem_read  <= 1'b1;
            pmem_write <= 1'b0;
            pmem_wmask <= 2'b11;
          end
        end
        D_PTR: begin
          if (pmem_resp) begin
            state      <= D_FIN;
            ptr        <= pmem_rdata;
            pmem_addr  <= pmem_rdata;
            pmem_read  <= !sv_write;
            pmem_write <= sv_write;
            pmem_wmask <= sv_write ? sv_wmask : 2'b11;
          end
        end
        I_ACC, D_ACC, D_FIN: begin
          if (pmem_resp) begin
            state      <= IDLE;
            pmem_read  <= 1'b0;
            pmem_write <= 1'b0;
          end
        end
        default: begin
          state      <= IDLE;
          pmem_read  <= 1'b0;
          pmem_write <= 1'b0;
        end
      endcase
    end
  end

  assign i_resp  = (state == I_ACC) && pmem_resp;
  assign d_resp  = ((state == D_ACC) || (state == D_FIN)) && pmem_resp;
  assign i_rdata = i_resp ? pmem_rdata : '0;
  assign d_rdata = d_resp ? pmem_rdata : '0;

  a_rw_exclusive: assert property (@(posedge clk) disable iff (!reset_n) !(d_read && d_write));
  a_ptr_held:     assert property (@(posedge clk) disable iff (!reset_n)
                                   (state == D_FIN) |-> (pmem_addr == ptr));

`ifdef LC3B_MEM_ARB_PERF_EN
  logic perf_conflict;
  logic perf_stall;

  assign perf_conflict = (state == IDLE) && data_req && i_read;
  assign perf_stall    = i_read && !i_resp;

  lc3b_arb_perf u_perf (
    .clk          (clk),
    .reset_n      (reset_n),
    .clear        (perf_clear),
    .conflict     (perf_conflict),
    .stall        (perf_stall),
    .conflict_cnt (perf_conflict_cnt),
    .stall_cnt    (perf_fetch_stall_cnt)
  );
`endif

endmodule

`default_nettype wire

// File: tb/tb_lc3b_mem_arbiter.sv
// tb_lc3b_mem_arbiter: table vectors, directed corner sequences and randomized traffic
// checked against a transaction-level memory model.
`default_nettype none

module tb_lc3b_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        i_read = 1'b0;
  logic [15:0] i_addr = '0;
  logic        i_resp;
  logic [15:0] i_rdata;
  logic        d_read = 1'b0;
  logic        d_write = 1'b0;
  logic        d_indirect = 1'b0;
  logic [15:0] d_addr = '0;
  logic [15:0] d_wdata = '0;
  logic [1:0]  d_wmask = '0;
  logic        d_resp;
  logic [15:0] d_rdata;
  logic        pmem_read;
  logic        pmem_write;
  logic [15:0] pmem_addr;
  logic [15:0] pmem_wdata;
  logic [1:0]  pmem_wmask;
  logic        pmem_resp;
  logic [15:0] pmem_rdata;
`ifdef LC3B_MEM_ARB_PERF_EN
  logic        perf_clear = 1'b0;
  logic [31:0] perf_conflict_cnt;
  logic [31:0] perf_fetch_stall_cnt;
`endif

  lc3b_mem_arbiter #(.MAX_D_STREAK(4)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .i_read     (i_read),
    .i_addr     (i_addr),
    .i_resp     (i_resp),
    .i_rdata    (i_rdata),
    .d_read     (d_read),
    .d_write    (d_write),
    .d_indirect (d_indirect),
    .d_addr     (d_addr),
    .d_wdata    (d_wdata),
    .d_wmask    (d_wmask),
    .d_resp     (d_resp),
    .d_rdata    (d_rdata),
    .pmem_read  (pmem_read),
    .pmem_write (pmem_write),
    .pmem_addr  (pmem_addr),
    .pmem_wdata (pmem_wdata),
    .pmem_wmask (pmem_wmask),
    .pmem_resp  (pmem_resp),
    .pmem_rdata (pmem_rdata)
`ifdef LC3B_MEM_ARB_PERF_EN
    ,
    .perf_clear           (perf_clear),
    .perf_conflict_cnt    (perf_conflict_cnt),
    .perf_fetch_stall_cnt (perf_fetch_stall_cnt)
`endif
  );

  initial forever #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Physical memory, a reference copy of it, and latency control.
  logic [15:0] mem     [0:65535];
  logic [15:0] ref_mem [0:65535];
  int  lat_fixed = 2;
  bit  rand_lat = 0;
  bit  abort = 0;
  int  cur_lat;
  int  mcnt;

  initial begin
    pmem_resp  <= 1'b0;
    pmem_rdata <= '0;
    mcnt = 0;
    cur_lat = 2;
    forever begin
      @(posedge clk or negedge reset_n);
      if (!reset_n) begin
        pmem_resp  <= 1'b0;
        pmem_rdata <= '0;
        mcnt = 0;
      end else if (pmem_resp) begin
        pmem_resp  <= 1'b0;
        pmem_rdata <= '0;
        mcnt = 0;
      end else if (pmem_read || pmem_write) begin
        mcnt++;
        if (mcnt >= (rand_lat ? cur_lat : lat_fixed)) begin
          mcnt = 0;
          pmem_resp <= 1'b1;
          if (pmem_write) begin
            if (pmem_wmask[1]) mem[pmem_addr][15:8] = pmem_wdata[15:8];
            if (pmem_wmask[0]) mem[pmem_addr][7:0]  = pmem_wdata[7:0];
            pmem_rdata <= '0;
          end else begin
            pmem_rdata <= mem[pmem_addr];
          end
          cur_lat = $urandom_range(1, 4);
        end
      end
    end
  end

  typedef struct {
    logic        wr;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [1:0]  wmask;
  } acc_t;
  acc_t acc_q[$];
  byte  resp_q[$];

  always @(negedge clk) begin
    if (pmem_resp && (pmem_read || pmem_write))
      acc_q.push_back('{pmem_write, pmem_addr, pmem_wdata, pmem_wmask});
    if (i_resp) resp_q.push_back("I");
    if (d_resp) resp_q.push_back("D");
    if (!i_resp) check("i_rdata_idle", {16'h0, i_rdata}, 32'h0);
    if (!d_resp) check("d_rdata_idle", {16'h0, d_rdata}, 32'h0);
  end

  task automatic do_fetch(input logic [15:0] a, output logic [15:0] rd, output bit ok);
    i_read = 1'b1;
    i_addr = a;
    ok = 0;
    rd = '0;
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      if (abort) break;
      if (i_resp) begin
        rd = i_rdata;
        ok = 1;
        break;
      end
    end
    @(posedge clk);
    #1;
    i_read = 1'b0;
    if (!abort) check("fetch_done", {31'h0, ok}, 32'h1);
  endtask

  task automatic do_data(input bit wr, input bit ind, input logic [15:0] a,
                         input logic [15:0] wd, input logic [1:0] wm,
                         output logic [15:0] rd, output bit ok);
    d_read     = !wr;
    d_write    = wr;
    d_indirect = ind;
    d_addr     = a;
    d_wdata    = wd;
    d_wmask    = wm;
    ok = 0;
    rd = '0;
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      if (abort) break;
      if (d_resp) begin
        rd = d_rdata;
        ok = 1;
        break;
      end
    end
    @(posedge clk);
    #1;
    d_read     = 1'b0;
    d_write    = 1'b0;
    d_indirect = 1'b0;
    if (!abort) check("data_done", {31'h0, ok}, 32'h1);
  endtask

  typedef struct {
    bit          is_d;
    bit          wr;
    bit          ind;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [1:0]  wmask;
    int          lat;
    logic [15:0] exp_rdata;
    int          nacc;
    logic [15:0] last_addr;
    logic [1:0]  last_mask;
    bit          last_wr;
  } vec_t;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, vectors %0d", vectors);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        tbl [8];
    logic [15:0] rd;
    bit          ok;
    byte         exp_order [7];
    int          n0;

    tbl[0] = '{0, 0, 0, 16'h3000, 16'h0000, 2'b11, 3, 16'h1234, 1, 16'h3000, 2'b11, 0};
    tbl[1] = '{1, 0, 0, 16'h0200, 16'h0000, 2'b11, 1, 16'hCAFE, 1, 16'h0200, 2'b11, 0};
    tbl[2] = '{1, 0, 1, 16'h0100, 16'h0000, 2'b11, 2, 16'hBEEF, 2, 16'h2000, 2'b11, 0};
    tbl[3] = '{1, 1, 1, 16'h0102, 16'h00AB, 2'b10, 3, 16'h0000, 2, 16'h3001, 2'b10, 1};
    tbl[4] = '{1, 1, 0, 16'h0200, 16'h1357, 2'b01, 1, 16'h0000, 1, 16'h0200, 2'b01, 1};
    tbl[5] = '{1, 0, 0, 16'h0200, 16'h0000, 2'b00, 2, 16'hCA57, 1, 16'h0200, 2'b11, 0};
    tbl[6] = '{1, 0, 1, 16'h0102, 16'h0000, 2'b11, 1, 16'h0066, 2, 16'h3001, 2'b11, 0};
    tbl[7] = '{0, 0, 0, 16'h3001, 16'h0000, 2'b11, 4, 16'h0066, 1, 16'h3001, 2'b11, 0};

    for (int a = 0; a < 65536; a++) mem[a] = 16'h0000;
    mem[16'h3000] = 16'h1234;
    mem[16'h3001] = 16'h5566;
    mem[16'h0100] = 16'h2000;
    mem[16'h2000] = 16'hBEEF;
    mem[16'h0102] = 16'h3001;
    mem[16'h0200] = 16'hCAFE;
    mem[16'h4000] = 16'h4444;
    mem[16'h3010] = 16'h0F10;
    mem[16'h3020] = 16'h0F20;

    // Reset state
    #1;
    check("rst_pmem_read",  {31'h0, pmem_read}, 32'h0);
    check("rst_pmem_write", {31'h0, pmem_write}, 32'h0);
    check("rst_pmem_addr",  {16'h0, pmem_addr}, 32'h0);
    check("rst_pmem_wdata", {16'h0, pmem_wdata}, 32'h0);
    check("rst_pmem_wmask", {30'h0, pmem_wmask}, 32'h0);
    check("rst_i_resp",     {31'h0, i_resp}, 32'h0);
    check("rst_d_resp",     {31'h0, d_resp}, 32'h0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    // Single-request table
    for (int i = 0; i < 8; i++) begin
      acc_q.delete();
      resp_q.delete();
      lat_fixed = tbl[i].lat;
      if (tbl[i].is_d)
        do_data(tbl[i].wr, tbl[i].ind, tbl[i].addr, tbl[i].wdata, tbl[i].wmask, rd, ok);
      else
        do_fetch(tbl[i].addr, rd, ok);
      if (!tbl[i].wr) check($sformatf("tbl%0d_rdata", i), {16'h0, rd}, {16'h0, tbl[i].exp_rdata});
      check($sformatf("tbl%0d_nacc", i), acc_q.size(), tbl[i].nacc);
      check($sformatf("tbl%0d_nresp", i), resp_q.size(), 1);
      if (acc_q.size() > 0) begin
        check($sformatf("tbl%0d_addr", i), {16'h0, acc_q[$].addr}, {16'h0, tbl[i].last_addr});
        check($sformatf("tbl%0d_wmask", i), {30'h0, acc_q[$].wmask}, {30'h0, tbl[i].last_mask});
        check($sformatf("tbl%0d_wr", i), {31'h0, acc_q[$].wr}, {31'h0, tbl[i].last_wr});
        if (tbl[i].wr) check($sformatf("tbl%0d_wdata", i), {16'h0, acc_q[$].wdata}, {16'h0, tbl[i].wdata});
      end
      if (acc_q.size() > 1) check($sformatf("tbl%0d_ptr_addr", i), {16'h0, acc_q[0].addr}, {16'h0, tbl[i].addr});
    end

    // Fetch only: strobe appears the cycle after grant
    acc_q.delete();
    resp_q.delete();
    lat_fixed = 3;
    fork
      begin
        do_fetch(16'h3000, rd, ok);
        check("fo_rdata", {16'h0, rd}, 32'h1234);
      end
      begin
        @(negedge clk);
        check("fo_pre_grant_read", {31'h0, pmem_read}, 32'h0);
        @(negedge clk);
        check("fo_strobe", {31'h0, pmem_read}, 32'h1);
        check("fo_addr", {16'h0, pmem_addr}, 32'h3000);
      end
    join
    check("fo_resp_count", resp_q.size(), 1);

    // Simultaneous fetch and data read
    acc_q.delete();
    resp_q.delete();
    lat_fixed = 2;
    fork
      begin
        do_fetch(16'h3010, rd, ok);
        check("sim_i_rdata", {16'h0, rd}, 32'h0F10);
      end
      begin
        logic [15:0] drd;
        bit          dok;
        do_data(0, 0, 16'h4000, 16'h0, 2'b11, drd, dok);
        check("sim_d_rdata", {16'h0, drd}, 32'h4444);
      end
      begin
        bit seen = 0;
        for (int n = 0; n < 300; n++) begin
          @(negedge clk);
          if (d_resp) begin
            seen = 1;
            break;
          end
        end
        check("sim_d_resp_seen", {31'h0, seen}, 32'h1);
        repeat (2) @(negedge clk);
        check("sim_fetch_grant", {31'h0, pmem_read}, 32'h1);
        check("sim_fetch_addr", {16'h0, pmem_addr}, 32'h3010);
      end
    join
    check("sim_order_n", resp_q.size(), 2);
    if (resp_q.size() == 2) begin
      check("sim_order0", {24'h0, resp_q[0]}, 32'h44);
      check("sim_order1", {24'h0, resp_q[1]}, 32'h49);
    end

    // Starvation limit
    resp_q.delete();
    lat_fixed = 1;
    exp_order = '{"D", "D", "D", "D", "I", "D", "D"};
    fork
      begin
        do_fetch(16'h3000, rd, ok);
      end
      begin
        logic [15:0] drd;
        bit          dok;
        for (int k = 0; k < 6; k++) do_data(0, 0, 16'h0200, 16'h0, 2'b11, drd, dok);
      end
    join
    check("starve_n", resp_q.size(), 7);
    for (int k = 0; k < 7 && k < resp_q.size(); k++)
      check($sformatf("starve_order%0d", k), {24'h0, resp_q[k]}, {24'h0, exp_order[k]});

    // LDI with fetch pending: no fetch between the two reads
    acc_q.delete();
    lat_fixed = 2;
    fork
      begin
        do_fetch(16'h3020, rd, ok);
        check("ldi_f_rdata", {16'h0, rd}, 32'h0F20);
      end
      begin
        logic [15:0] drd;
        bit          dok;
        do_data(0, 1, 16'h0100, 16'h0, 2'b11, drd, dok);
        check("ldi_rdata", {16'h0, drd}, 32'hBEEF);
      end
    join
    check("ldi_nacc", acc_q.size(), 3);
    if (acc_q.size() == 3) begin
      check("ldi_acc0", {16'h0, acc_q[0].addr}, 32'h0100);
      check("ldi_acc1", {16'h0, acc_q[1].addr}, 32'h2000);
      check("ldi_acc2", {16'h0, acc_q[2].addr}, 32'h3020);
    end

    // Reset during the pointer read
    lat_fixed = 4;
    n0 = resp_q.size();
    fork
      begin
        logic [15:0] drd;
        bit          dok;
        do_data(0, 1, 16'h0100, 16'h0, 2'b11, drd, dok);
      end
      begin
        bit seen = 0;
        for (int n = 0; n < 50; n++) begin
          @(negedge clk);
          if (pmem_read && pmem_addr == 16'h0100) begin
            seen = 1;
            break;
          end
        end
        check("rst_mid_dptr_seen", {31'h0, seen}, 32'h1);
        reset_n = 1'b0;
        #1;
        check("rst_mid_pmem_read", {31'h0, pmem_read}, 32'h0);
        check("rst_mid_d_resp", {31'h0, d_resp}, 32'h0);
        abort = 1;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
      end
    join
    check("rst_mid_no_resp", resp_q.size(), n0);
    abort = 0;
    @(posedge clk);
    #1;
    lat_fixed = 2;
    do_fetch(16'h3000, rd, ok);
    check("rst_after_fetch", {16'h0, rd}, 32'h1234);

    // Randomized concurrent traffic against the reference memory
    for (int a = 16'h3000; a < 16'h3100; a++) begin
      mem[a] = 16'($urandom);
      ref_mem[a] = mem[a];
    end
    for (int a = 16'h0400; a < 16'h0500; a++) begin
      mem[a] = 16'($urandom);
      ref_mem[a] = mem[a];
    end
    for (int a = 16'h0080; a < 16'h0100; a++) begin
      mem[a] = 16'h0400 + 16'($urandom_range(0, 255));
      ref_mem[a] = mem[a];
    end
    rand_lat = 1;
    fork
      begin
        logic [15:0] fa;
        logic [15:0] frd;
        logic [15:0] fexp;
        bit          fok;
        for (int k = 0; k < 40; k++) begin
          fa = 16'h3000 + 16'($urandom_range(0, 255));
          fexp = ref_mem[fa];
          do_fetch(fa, frd, fok);
          if (fok) check("rand_i_rdata", {16'h0, frd}, {16'h0, fexp});
          repeat ($urandom_range(0, 3)) @(posedge clk);
          #1;
        end
      end
      begin
        logic [15:0] da;
        logic [15:0] tgt;
        logic [15:0] dwd;
        logic [15:0] drd;
        logic [15:0] dexp;
        logic [1:0]  dwm;
        bit          dwr;
        bit          dind;
        bit          dok;
        for (int k = 0; k < 40; k++) begin
          dwr  = 1'($urandom_range(0, 1));
          dind = 1'($urandom_range(0, 1));
          if (dind) begin
            da  = 16'h0080 + 16'($urandom_range(0, 127));
            tgt = ref_mem[da];
          end else begin
            da  = 16'h0400 + 16'($urandom_range(0, 255));
            tgt = da;
          end
          dwd  = 16'($urandom);
          dwm  = 2'($urandom_range(0, 3));
          dexp = ref_mem[tgt];
          do_data(dwr, dind, da, dwd, dwm, drd, dok);
          if (dok && !dwr) check("rand_d_rdata", {16'h0, drd}, {16'h0, dexp});
          if (dok && dwr) begin
            if (dwm[1]) ref_mem[tgt][15:8] = dwd[15:8];
            if (dwm[0]) ref_mem[tgt][7:0]  = dwd[7:0];
          end
          repeat ($urandom_range(0, 2)) @(posedge clk);
          #1;
        end
      end
    join
    rand_lat = 0;
    for (int a = 16'h0400; a < 16'h0500; a++)
      check("rand_mem_final", {16'h0, mem[a]}, {16'h0, ref_mem[a]});

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
